// File: rtl/green_pkg.sv
// Shared types for the Green 16-bit datapath front end: widths, fetch FSM
// states and the prefetch buffer entry layout.
package green_pkg;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DW-1:0] ins;
    logic [AW-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/ins_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack on one side, the
// instruction stream to load/execute on the other.
interface ins_fetch_if;
  import green_pkg::*;

  // mem_req is held with a stable mem_addr until a one-cycle mem_ack returns
  // mem_rdata; an instruction transfers on any edge with ins_valid & ins_ready.
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic          ins_valid;
  logic          ins_ready;

  modport master (
    output mem_req, mem_addr, ins, ins_pc, ins_valid,
    input  mem_ack, mem_rdata, ins_ready
  );

  modport slave (
    input  mem_req, mem_addr, ins, ins_pc, ins_valid,
    output mem_ack, mem_rdata, ins_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Register FIFO for prefetched instructions. Flush wins over push and pop;
// the head is read straight from the storage registers.
module fetch_fifo
  import green_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic          head_valid,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC and the fetch FSM, issues one word
// read at a time and streams results through the prefetch buffer.
module ins_fetch
  import green_pkg::*;
#(
  parameter  int            DEPTH    = 2,
  parameter  logic [AW-1:0] RESET_PC = '0,
  localparam int            CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               br_valid,
  input  logic [AW-1:0]      br_target,
  ins_fetch_if.master        bus,
  output fetch_state_t       state,
  output logic [CW-1:0]      count
);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [AW-1:0] pc;
  logic [AW-1:0] addr_q;
  logic          req_q;
  logic          push;
  logic          pop;
  logic [CW:0]   count_ext;
  logic [CW:0]   count_after;
  fetch_entry_t  head;

  // A redirect cycle neither consumes the head nor keeps the returning word.
  assign pop         = bus.ins_valid & bus.ins_ready & ~br_valid;
  assign push        = (state == FETCH) & bus.mem_ack & ~br_valid;
  assign count_ext   = {1'b0, count};
  assign count_after = count_ext + (CW + 1)'(1) - (CW + 1)'(pop);

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.ins      = head.ins;
  assign bus.ins_pc   = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (br_valid),
    .wdata      ({bus.mem_rdata, pc}),
    .head       (head),
    .head_valid (bus.ins_valid),
    .count      (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      if (br_valid)  pc <= br_target;
      else if (push) pc <= pc + AW'(1);

      case (state)
        IDLE: begin
          if (run && (br_valid || count_ext < DEPTH_C)) begin
            state  <= FETCH;
            req_q  <= 1'b1;
            addr_q <= br_valid ? br_target : pc;
          end
        end
        FETCH: begin
          // Chaining the next request is only allowed with a free slot reserved.
          if (bus.mem_ack) begin
            if (br_valid ? run : (run && count_after < DEPTH_C)) begin
              addr_q <= br_valid ? br_target : pc + AW'(1);
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end else if (br_valid) begin
            state <= DROP;
          end
        end
        DROP: begin
          // The stale request must still complete before the target is fetched.
          if (bus.mem_ack) begin
            if (run) begin
              state  <= FETCH;
              addr_q <= br_valid ? br_target : pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: memory responder, stream scoreboard fed by a
// sequential-address reference model, directed scenarios then random traffic.
module tb_ins_fetch;
  import green_pkg::*;

  localparam int W = DW + AW;

  logic          clk;
  logic          rst;
  logic          run;
  logic          br_valid;
  logic [AW-1:0] br_target;
  fetch_state_t  state;
  logic [1:0]    count;

  ins_fetch_if bus ();

  ins_fetch #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .br_valid  (br_valid),
    .br_target (br_target),
    .bus       (bus),
    .state     (state),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [DW-1:0] mem [256];
  logic [W-1:0]  exp_q[$];
  int n_vec   = 0;
  int n_err   = 0;
  int acc_cnt = 0;
  int ack_cnt = 0;
  int lat_max = 0;
  int wait_cnt = 0;
  bit hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after reset or a redirect the consumer sees consecutive
  // addresses from the start point, each carrying that address's memory word.
  task automatic new_segment(input logic [AW-1:0] start);
    logic [AW-1:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({mem[p], p});
      p = p + 8'd1;
    end
  endtask

  // ---------------- memory responder ----------------
  always begin
    @(posedge clk);
    #2;
    bus.mem_ack = 1'b0;
    if (!rst && bus.mem_req && !hold) begin
      if (wait_cnt == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        ack_cnt++;
        wait_cnt = $urandom_range(0, lat_max);
      end else begin
        wait_cnt--;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && bus.ins_valid && bus.ins_ready && !br_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ins_stream: got pc %0h with no instruction expected", bus.ins_pc);
      end else begin
        e = exp_q.pop_front();
        check("ins_pc", 32'(bus.ins_pc), 32'(e[AW-1:0]));
        check("ins", 32'(bus.ins), 32'(e[W-1:AW]));
      end
      acc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [AW-1:0] t);
    br_valid  = 1'b1;
    br_target = t;
    new_segment(t);
    step();
    br_valid = 1'b0;
  endtask

  task automatic wait_accepts(input string name, input int n, input int budget);
    int target;
    target = acc_cnt + n;
    for (int c = 0; c < budget && acc_cnt < target; c++) step();
    check(name, 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle_drained(input int budget);
    for (int c = 0; c < budget && !(state == IDLE && !bus.ins_valid); c++) step();
    check("idle_drained", 32'(state == IDLE && !bus.ins_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h00);
    check({tag, "_ins"}, 32'(bus.ins), 32'd0);
    check({tag, "_ins_pc"}, 32'(bus.ins_pc), 32'd0);
    check({tag, "_ins_valid"}, 32'(bus.ins_valid), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int since;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    rst           = 1'b0;
    run           = 1'b1;
    br_valid      = 1'b0;
    br_target     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.ins_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    check("reset_state", 32'(state), 32'(IDLE));

    // Reset release with run=1 and a stalled consumer: two fetches fill the buffer.
    @(negedge clk);
    #1 rst = 1'b0;
    new_segment(8'h00);
    step();
    check("first_req", 32'(bus.mem_req), 32'd1);
    check("first_addr", 32'(bus.mem_addr), 32'h00);
    repeat (6) step();
    check("stall_acks", 32'(ack_cnt), 32'd2);
    check("stall_req_low", 32'(bus.mem_req), 32'd0);
    check("stall_count", 32'(count), 32'd2);
    check("stall_head_pc", 32'(bus.ins_pc), 32'h00);

    // Resume: stream continues without loss or duplication, then 1/cycle.
    bus.ins_ready = 1'b1;
    wait_accepts("resume", 10, 14);
    wait_accepts("throughput", 16, 17);

    // PC wrap FE -> FF -> 00.
    branch(8'hFE);
    wait_accepts("wrap", 3, 8);

    // Redirect coincident with ack and a head transfer.
    br_valid  = 1'b1;
    br_target = 8'h80;
    new_segment(8'h80);
    #2;
    check("coinc_ack", 32'(bus.mem_ack), 32'd1);
    check("coinc_xfer", 32'(bus.ins_valid & bus.ins_ready), 32'd1);
    step();
    br_valid = 1'b0;
    check("coinc_state", 32'(state), 32'(FETCH));
    check("coinc_addr", 32'(bus.mem_addr), 32'h80);
    check("coinc_flushed", 32'(bus.ins_valid), 32'd0);
    wait_accepts("coinc_stream", 4, 8);

    // Redirect while a request to 05 is pending; 05 must never surface.
    run = 1'b0;
    wait_idle_drained(12);
    hold = 1'b1;
    run  = 1'b1;
    branch(8'h05);
    check("drop_req_addr", 32'(bus.mem_addr), 32'h05);
    branch(8'h40);
    for (int i = 0; i < 3; i++) begin
      check("drop_state", 32'(state), 32'(DROP));
      check("drop_addr_hold", 32'(bus.mem_addr), 32'h05);
      check("drop_req_hold", 32'(bus.mem_req), 32'd1);
      if (i < 2) step();
    end
    hold = 1'b0;
    step();
    check("drop_next_addr", 32'(bus.mem_addr), 32'h40);
    check("drop_next_state", 32'(state), 32'(FETCH));
    wait_accepts("drop_stream", 4, 10);

    // Random traffic: latency, back-pressure, run gating and redirects.
    lat_max = 3;
    since   = 0;
    for (int c = 0; c < 400; c++) begin
      bus.ins_ready = ($urandom_range(0, 3) != 0);
      run           = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0 || since >= 100) begin
        branch(AW'($urandom_range(0, 255)));
        since = 0;
      end else begin
        step();
        since++;
      end
    end
    bus.ins_ready = 1'b1;
    run           = 1'b1;
    wait_accepts("random_alive", 4, 40);

    // Asynchronous reset in the middle of streaming.
    lat_max = 0;
    wait_accepts("pre_reset", 2, 20);
    #2 rst = 1'b1;
    bus.mem_ack = 1'b0;
    wait_cnt    = 0;
    exp_q.delete();
    #1 check_reset_outputs("async");
    check("async_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    #1 rst = 1'b0;
    new_segment(8'h00);
    step();
    check("rerun_req", 32'(bus.mem_req), 32'd1);
    check("rerun_addr", 32'(bus.mem_addr), 32'h00);
    wait_accepts("rerun_stream", 4, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage of the Green 16-bit datapath. It keeps the 8-bit program counter and issues word reads to instruction memory over a req/ack handshake. Returned words go into a small prefetch buffer, which presents `ins` and `ins_pc` to the load/execute stage with a valid/ready handshake. A branch redirect flushes the buffer and any in-flight fetch.

## Interface
- `AW`, 8: instruction address width (matches the 8-bit `addr` field).
- `DW`, 16: instruction width.
- `DEPTH`, 2: prefetch buffer entries (power of two, ≥2).
- `RESET_PC`, 8'h00: PC value after reset.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  fetch enable; low = issue no new requests.
- `br_valid`  in  1  one-cycle redirect pulse.
- `br_target`  in  AW  new PC on redirect.
- `mem_req`  out  1  read request, held until ack.
- `mem_addr`  out  AW  read address, stable while `mem_req`=1.
- `mem_ack`  in  1  one-cycle completion; `mem_rdata` valid this cycle.
- `mem_rdata`  in  DW  instruction word.
- `ins`  out  DW  head instruction.
- `ins_pc`  out  AW  address of `ins`.
- `ins_valid`  out  1  head entry valid.
- `ins_ready`  in  1  consumer accepts head when `ins_valid`=1.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `ins`=0, `ins_pc`=0, `ins_valid`=0. The PC is `RESET_PC`, the buffer is empty, and the state is IDLE.
- FSM states are IDLE, FETCH and DROP.
- IDLE → FETCH when `run`=1, `br_valid`=0 and `count`<`DEPTH`.
- In FETCH, `mem_req`=1 and `mem_addr`=PC.
- On `mem_ack` in FETCH:
  - push {`mem_rdata`, PC}.
  - PC←PC+1, wrapping 8'hFF→8'h00.
  - Stay in FETCH (back-to-back, `mem_req` stays high with the new address) if `run`=1 and post-push/pop `count`<`DEPTH`; otherwise go to IDLE.
- Invariant: `count` + outstanding ≤ `DEPTH`. A request is only issued with space reserved, so a push never overflows.
- `br_valid`=1 has priority over everything:
  - Flush the buffer; `ins_valid`=0 next cycle, and no pop occurs that cycle.
  - PC←`br_target`.
  - In FETCH with no ack in the same cycle, go to DROP.
  - In FETCH with an ack in the same cycle, discard the data and go to FETCH if `run`=1, else IDLE.
  - In IDLE, go to FETCH if `run`=1.
- DROP: keep `mem_req`=1 with the old address, since a request is never abandoned. Discard the data on ack, then go to FETCH at `br_target` if `run`=1, else IDLE. A further `br_valid` in DROP only updates the PC.
- `run`=0 does not cancel an outstanding request. It completes and is pushed normally, then the FSM goes to IDLE.
- Pop when `ins_valid` & `ins_ready`. Push and pop in the same cycle are both allowed.

## Timing
- Ack to `ins_valid`: 1 cycle. The word is written at the ack edge and visible the next cycle when the buffer was empty.
- Reset release with `run`=1: `mem_req` is high in the first cycle after the first edge (IDLE→FETCH).
- Redirect to first request at the target: 1 cycle from IDLE or FETCH. From DROP it is 1 cycle after the pending ack.
- Sustained throughput is 1 instruction/cycle with single-cycle ack and `ins_ready`=1.
- `ins`, `ins_pc` and `ins_valid` are driven directly from the buffer head registers, with no combinational path from `mem_rdata`.
- `ins` and `ins_pc` hold their value while `ins_valid`=1 and `ins_ready`=0.

## Structure
- Shared package `green_pkg`:
  - `AW`/`DW` constants.
  - fetch state enum {IDLE, FETCH, DROP}.
  - a packed fetch-entry typedef {ins, pc}.
- Sub-module `fetch_fifo`: DEPTH-entry register FIFO with push/pop/flush, a `count` output and head outputs. Flush has priority over push and pop.
- The FSM and PC live in `ins_fetch`.

## Test plan
- Reset with `RESET_PC`=8'h00, `run`=1, ack the cycle after each req, `ins_ready`=1. Expect `ins_pc` 00,01,02… on consecutive cycles and `ins` equal to the memory words.
- `ins_ready`=0. Expect exactly 2 requests, then `mem_req`=0 with `count`=2. Raise `ins_ready`: fetching resumes at PC=02 with no loss or duplication.
- Start at PC=8'hFE and fetch 3 words. Expect `ins_pc` FE, FF, 00.
- `br_valid` with target 8'h40 while a request to 05 awaits ack, then ack 3 cycles later. Expect `mem_addr` to stay 05 until ack, the word from 05 never to appear, and the next `mem_addr` to be 40 with first `ins_pc`=40.
- `br_valid` coincident with `mem_ack` and `ins_valid`&`ins_ready`. Expect the buffer flushed, the acked word discarded, and the next request at `br_target`.
- Assert `rst` mid-fetch. Expect all outputs at reset values immediately (asynchronously) and the first request at `RESET_PC` after release.
